bcd_count_ctrl: RTL and testbench

//  Run/pause/terminal sequencer for the multi-digit BCD up/down counter datapath.

---
 rtl/bcd_ctrl_pkg.sv | 18 +
 rtl/bcd_digit.sv | 46 ++++
 rtl/bcd_count_ctrl.sv | 138 +++++++++++++
 tb/tb_bcd_count_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_ctrl_pkg.sv
// Shared encodings and helpers for the BCD counter sequencer.
// State codes are fixed by the board-level display and LED decode.
package bcd_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam int unsigned DIGITS_DEF = 4;

  // Out-of-range preset nibbles saturate to 9 rather than producing non-BCD codes.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit of the up/down counter.
// lim_c reports that an enabled step in the current direction would carry/borrow out.
module bcd_digit
  import bcd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       wrap_allow,
  input  logic       load,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       lim_c
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  assign q     = q_q;
  assign lim_c = dir ? (q_q == BCD_MAX) : (q_q == 4'd0);

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = bcd_clamp(ld_val);
    end else if (en) begin
      if (lim_c) begin
        if (wrap_allow) begin
          q_d = dir ? 4'd0 : BCD_MAX;
        end
      end else begin
        q_d = dir ? (q_q + 4'd1) : (q_q - 4'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run/pause/terminal sequencer for the multi-digit BCD counter: prescaler,
// command arbitration (clear > load > stop > start) and terminal-count policy.
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned DIGITS  = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  input  logic                  dir_i,
  input  logic                  wrap_en_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  tick_o,
  output logic [1:0]            state_o,
  output logic                  done_o
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("bcd_count_ctrl: CLK_HZ/TICK_HZ must be at least 2");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  logic             step_c;
  logic             dig_load_c;
  logic [W-1:0]     dig_val_c;
  logic [DIGITS-1:0] lim_c;
  logic [DIGITS-1:0] en_c;
  logic             terminal_c;

  // Every digit sits at its limit for the current direction: 9999.. up, 0000.. down.
  assign terminal_c = &lim_c;

  assign state_o = state_q;
  assign tick_o  = tick_q;
  assign done_o  = done_q;

  // Command arbitration, prescaler and next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;
    step_c     = 1'b0;
    dig_load_c = 1'b0;
    dig_val_c  = load_val_i;

    if (clear_i) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      dig_load_c = 1'b1;
      dig_val_c  = '0;
    end else if (load_i && (state_q != ST_RUN)) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      dig_load_c = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (stop_i) begin
            state_d = ST_PAUSE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (terminal_c && !wrap_en_i) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              step_c = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_IDLE, ST_PAUSE: begin
          if (start_i) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  // Digit i steps only when the step fires and all lower digits carry/borrow.
  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
    if (i == 0) begin : g_en0
      assign en_c[i] = step_c;
    end else begin : g_enn
      assign en_c[i] = step_c & (&lim_c[i-1:0]);
    end

    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .en         (en_c[i]),
      .dir        (dir_i),
      .wrap_allow (wrap_en_i),
      .load       (dig_load_c),
      .ld_val     (dig_val_c[4*i +: 4]),
      .q          (bcd_o[4*i +: 4]),
      .lim_c      (lim_c[i])
    );
  end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Self-checking bench for bcd_count_ctrl (DIV=8, 4 digits): directed scenarios
// plus randomized commands checked against an integer-valued reference model.
module tb_bcd_count_ctrl;

  localparam int CLK_HZ  = 8;
  localparam int TICK_HZ = 1;
  localparam int DIGITS  = 4;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int MAXV    = 9999;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0, stop_i = 1'b0, clear_i = 1'b0, load_i = 1'b0;
  logic [15:0] load_val_i = 16'h0000;
  logic        dir_i = 1'b1, wrap_en_i = 1'b1;
  logic [15:0] bcd_o;
  logic        tick_o;
  logic [1:0]  state_o;
  logic        done_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bcd_count_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .clear_i    (clear_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .dir_i      (dir_i),
    .wrap_en_i  (wrap_en_i),
    .bcd_o      (bcd_o),
    .tick_o     (tick_o),
    .state_o    (state_o),
    .done_o     (done_o)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = 16'h0000;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int load_to_int(input logic [15:0] lv);
    int r, p, d;
    r = 0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      r = r + d * p;
      p = p * 10;
    end
    return r;
  endfunction

  // Reference model: counter value as a plain integer, prescaler as a cycle count.
  int         m_val;
  int         m_cnt;
  logic [1:0] m_state;
  logic       m_tick, m_done;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_val <= 0; m_cnt <= 0; m_state <= S_IDLE; m_tick <= 1'b0; m_done <= 1'b0;
    end else begin
      m_tick <= 1'b0;
      m_done <= 1'b0;
      if (clear_i) begin
        m_val <= 0; m_cnt <= 0; m_state <= S_IDLE;
      end else if (load_i && m_state != S_RUN) begin
        m_val <= load_to_int(load_val_i); m_cnt <= 0; m_state <= S_IDLE;
      end else if (m_state == S_RUN) begin
        if (stop_i) begin
          m_state <= S_PAUSE; m_cnt <= 0;
        end else if (m_cnt == DIV - 1) begin
          m_cnt  <= 0;
          m_tick <= 1'b1;
          if ((dir_i && m_val == MAXV) || (!dir_i && m_val == 0)) begin
            if (wrap_en_i) m_val <= dir_i ? 0 : MAXV;
            else begin m_state <= S_DONE; m_done <= 1'b1; end
          end else begin
            m_val <= dir_i ? m_val + 1 : m_val - 1;
          end
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else if (m_state != S_DONE && start_i) begin
        m_state <= S_RUN; m_cnt <= 0;
      end
    end
  end

  // Drive one-cycle command pulses starting at the current falling edge.
  task automatic pulse(input logic s, input logic p, input logic c, input logic l);
    start_i = s; stop_i = p; clear_i = c; load_i = l;
    @(negedge clk);
    start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0; load_i = 1'b0;
  endtask

  // Count falling edges until tick_o is seen, bounded.
  task automatic tick_wait(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick_o !== 1'b1 && n < 40);
  endtask

  task automatic test_reset();
    start_i = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (bcd_o !== 16'h0000) $display("FAIL reset_bcd: got %h want 0000", bcd_o); else n_pass++;
    n_chk++; if (state_o !== S_IDLE) $display("FAIL reset_state: got %b want 00", state_o); else n_pass++;
    n_chk++; if (tick_o !== 1'b0 || done_o !== 1'b0)
      $display("FAIL reset_pulses: tick=%b done=%b want 0 0", tick_o, done_o); else n_pass++;
    start_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_count_up();
    int n;
    dir_i = 1'b1; wrap_en_i = 1'b1;
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    n_chk++; if (state_o !== S_RUN) $display("FAIL up_start_state: got %b want 01", state_o); else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      tick_wait(n);
      n_chk++; if (n !== DIV) $display("FAIL up_tick_period[%0d]: got %0d cycles want %0d", k, n, DIV); else n_pass++;
      n_chk++; if (bcd_o !== to_bcd(k)) $display("FAIL up_value[%0d]: got %h want %h", k, bcd_o, to_bcd(k)); else n_pass++;
    end
    n_chk++; if (bcd_o !== 16'h0010) $display("FAIL up_tenth: got %h want 0010", bcd_o); else n_pass++;
    pulse(0, 1, 0, 0);
    n_chk++; if (state_o !== S_PAUSE) $display("FAIL up_stop_state: got %b want 10", state_o); else n_pass++;
  endtask

  task automatic test_terminal_stop();
    int n;
    pulse(0, 0, 1, 0);
    load_val_i = 16'h9998; dir_i = 1'b1; wrap_en_i = 1'b0;
    pulse(0, 0, 0, 1);
    pulse(1, 0, 0, 0);
    tick_wait(n);
    n_chk++; if (bcd_o !== 16'h9999 || state_o !== S_RUN)
      $display("FAIL term_first: got %h/%b want 9999/01", bcd_o, state_o); else n_pass++;
    tick_wait(n);
    n_chk++; if (n !== DIV) $display("FAIL term_period: got %0d want %0d", n, DIV); else n_pass++;
    n_chk++; if (bcd_o !== 16'h9999 || state_o !== S_DONE || done_o !== 1'b1)
      $display("FAIL term_done: got %h/%b/done=%b want 9999/11/1", bcd_o, state_o, done_o); else n_pass++;
    @(negedge clk);
    n_chk++; if (done_o !== 1'b0) $display("FAIL term_done_pulse: got %b want 0", done_o); else n_pass++;
    pulse(1, 0, 0, 0);
    repeat (DIV + 2) @(negedge clk);
    n_chk++; if (state_o !== S_DONE || bcd_o !== 16'h9999)
      $display("FAIL term_start_ignored: got %b/%h want 11/9999", state_o, bcd_o); else n_pass++;
  endtask

  task automatic test_wrap_down();
    int n;
    pulse(0, 0, 1, 0);
    load_val_i = 16'h0001; dir_i = 1'b0; wrap_en_i = 1'b1;
    pulse(0, 0, 0, 1);
    pulse(1, 0, 0, 0);
    tick_wait(n);
    n_chk++; if (bcd_o !== 16'h0000) $display("FAIL down_zero: got %h want 0000", bcd_o); else n_pass++;
    tick_wait(n);
    n_chk++; if (bcd_o !== 16'h9999 || state_o !== S_RUN || done_o !== 1'b0)
      $display("FAIL down_wrap: got %h/%b/done=%b want 9999/01/0", bcd_o, state_o, done_o); else n_pass++;
  endtask

  // Entered right after a tick; stop lands on the next tick cycle.
  task automatic test_stop_on_tick();
    int n;
    repeat (DIV - 1) @(negedge clk);
    pulse(0, 1, 0, 0);
    n_chk++; if (tick_o !== 1'b0 || state_o !== S_PAUSE || bcd_o !== 16'h9999)
      $display("FAIL stop_tick: got tick=%b %b/%h want 0 10/9999", tick_o, state_o, bcd_o); else n_pass++;
    pulse(1, 0, 0, 0);
    tick_wait(n);
    n_chk++; if (n !== DIV) $display("FAIL resume_period: got %0d want %0d", n, DIV); else n_pass++;
    n_chk++; if (bcd_o !== 16'h9998) $display("FAIL resume_value: got %h want 9998", bcd_o); else n_pass++;
  endtask

  task automatic test_load();
    pulse(0, 0, 1, 0);
    load_val_i = 16'h00A5;
    pulse(0, 0, 0, 1);
    n_chk++; if (bcd_o !== 16'h0095 || state_o !== S_IDLE)
      $display("FAIL load_clamp: got %h/%b want 0095/00", bcd_o, state_o); else n_pass++;
    dir_i = 1'b1;
    pulse(1, 0, 0, 0);
    repeat (2) @(negedge clk);
    load_val_i = 16'h1234;
    pulse(0, 0, 0, 1);
    n_chk++; if (bcd_o !== 16'h0095 || state_o !== S_RUN)
      $display("FAIL load_in_run: got %h/%b want 0095/01", bcd_o, state_o); else n_pass++;
    pulse(0, 0, 1, 1);
    n_chk++; if (bcd_o !== 16'h0000 || state_o !== S_IDLE)
      $display("FAIL clear_over_load: got %h/%b want 0000/00", bcd_o, state_o); else n_pass++;
  endtask

  task automatic test_async_reset();
    int n;
    load_val_i = 16'h0041; dir_i = 1'b1;
    pulse(0, 0, 0, 1);
    pulse(1, 0, 0, 0);
    tick_wait(n);
    n_chk++; if (bcd_o !== 16'h0042 || tick_o !== 1'b1)
      $display("FAIL arst_setup: got %h tick=%b want 0042 1", bcd_o, tick_o); else n_pass++;
    #1 rst = 1'b0;
    #1;
    n_chk++; if (bcd_o !== 16'h0000 || state_o !== S_IDLE || tick_o !== 1'b0 || done_o !== 1'b0)
      $display("FAIL arst_clear: got %h/%b tick=%b done=%b want 0000/00 0 0", bcd_o, state_o, tick_o, done_o);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      n_chk++; if (bcd_o !== to_bcd(m_val)) $display("FAIL rnd_bcd @%0d: got %h want %h", c, bcd_o, to_bcd(m_val)); else n_pass++;
      n_chk++; if (state_o !== m_state) $display("FAIL rnd_state @%0d: got %b want %b", c, state_o, m_state); else n_pass++;
      n_chk++; if (tick_o !== m_tick) $display("FAIL rnd_tick @%0d: got %b want %b", c, tick_o, m_tick); else n_pass++;
      n_chk++; if (done_o !== m_done) $display("FAIL rnd_done @%0d: got %b want %b", c, done_o, m_done); else n_pass++;
      clear_i = ($urandom_range(0, 199) == 0);
      load_i  = ($urandom_range(0, 49) == 0);
      stop_i  = ($urandom_range(0, 39) == 0);
      start_i = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) dir_i = ~dir_i;
      if ($urandom_range(0, 47) == 0) wrap_en_i = ~wrap_en_i;
      case ($urandom_range(0, 3))
        0:       load_val_i = 16'h9997;
        1:       load_val_i = 16'h0002;
        default: load_val_i = 16'($urandom);
      endcase
      @(negedge clk);
    end
    start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0; load_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count_up();
    test_terminal_stop();
    test_wrap_down();
    test_stop_on_tick();
    test_load();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
